// File: rtl/imem_responder_if.sv
// -----------------------------------------------------------------------------
// imem_responder_if
//   Fetch <-> instruction-memory channel bundle.
//   Request channel : req_valid / req_ready / req_pc (byte address)
//   Cancel          : flush (drop any outstanding or pending response)
//   Response channel: resp_valid / resp_ready / resp_pc / resp_instr / resp_err
//   master modport = fetch stage, slave modport = memory responder.
// -----------------------------------------------------------------------------
interface imem_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_pc;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_pc;
  logic [31:0] resp_instr;
  logic        resp_err;

  modport master (
    output req_valid, req_pc, flush, resp_ready,
    input  req_ready, resp_valid, resp_pc, resp_instr, resp_err
  );

  modport slave (
    input  req_valid, req_pc, flush, resp_ready,
    output req_ready, resp_valid, resp_pc, resp_instr, resp_err
  );
endinterface

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//   Instruction-memory responder. Accepts one PC at a time, returns the 32-bit
//   word LATENCY cycles after acceptance, flags misaligned / out-of-range PCs.
//   Ports:
//     clk        system clock (rising edge)
//     reset      synchronous active-low reset
//     bus        imem_if.slave : request/response handshake + flush
//     prog_we    loader write enable
//     prog_addr  loader word address
//     prog_data  loader write data
//   Parameters: ADDR_WIDTH (array depth 2^ADDR_WIDTH words), LATENCY (1..15),
//   BASE_ADDR (byte address of word 0).
// -----------------------------------------------------------------------------
module imem_responder #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_3000
) (
  input  logic                  clk,
  input  logic                  reset,
  imem_if.slave                 bus,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [31:0]           prog_data
);

  localparam logic [31:0] DEPTH_WORDS = 32'd1 << ADDR_WIDTH;
  localparam logic [3:0]  LOAD_CNT    = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Unsigned subtraction: a PC below BASE_ADDR wraps to a huge offset and
  // therefore lands in the out-of-range check.
  function automatic logic pc_err(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (((pc - BASE_ADDR) >> 2) >= DEPTH_WORDS);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] pc_index(input logic [31:0] pc);
    return ADDR_WIDTH'((pc - BASE_ADDR) >> 2);
  endfunction

  logic [31:0] mem_q [0:(1 << ADDR_WIDTH)-1];

  state_e      state_q,      state_d;
  logic [3:0]  cnt_q,        cnt_d;
  logic [31:0] pc_q,         pc_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_pc_q,    resp_pc_d;
  logic [31:0] resp_instr_q, resp_instr_d;
  logic        resp_err_q,   resp_err_d;

  logic        req_ready_s;
  logic        accept_s;
  logic        capture_s;
  logic [31:0] lookup_pc_s;
  logic        lookup_err_s;
  logic [31:0] lookup_word_s;

  // Ready is gated by reset and flush combinationally so neither can sneak a
  // request in during the cycle they are asserted.
  assign req_ready_s = reset && !bus.flush && (state_q == ST_IDLE);
  assign accept_s    = bus.req_valid && req_ready_s;

  // With LATENCY==1 the read is captured on the accepting edge itself, so the
  // PC comes straight from the request rather than from the latched copy.
  assign lookup_pc_s   = (state_q == ST_IDLE) ? bus.req_pc : pc_q;
  assign lookup_err_s  = pc_err(lookup_pc_s);
  assign lookup_word_s = mem_q[pc_index(lookup_pc_s)];

  assign bus.req_ready  = req_ready_s;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_pc    = resp_pc_q;
  assign bus.resp_instr = resp_instr_q;
  assign bus.resp_err   = resp_err_q;

  // Next-state and next-output computation for the request/response FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_d         = pc_q;
    resp_valid_d = resp_valid_q;
    resp_pc_d    = resp_pc_q;
    resp_instr_d = resp_instr_q;
    resp_err_d   = resp_err_q;
    capture_s    = 1'b0;

    if (bus.flush) begin
      // Flush wins over any handshake in the same cycle; response data is
      // left holding its last value, only valid drops.
      state_d      = ST_IDLE;
      cnt_d        = 4'd0;
      resp_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            pc_d = bus.req_pc;
            if (LATENCY == 1) begin
              state_d   = ST_RESP;
              cnt_d     = 4'd0;
              capture_s = 1'b1;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = LOAD_CNT;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_d   = ST_RESP;
            cnt_d     = 4'd0;
            capture_s = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b0;
          end else begin
            state_d = ST_RESP;
          end
        end
        default: begin
          state_d      = ST_IDLE;
          cnt_d        = 4'd0;
          resp_valid_d = 1'b0;
        end
      endcase
    end

    if (capture_s) begin
      resp_valid_d = 1'b1;
      resp_pc_d    = lookup_pc_s;
      if (lookup_err_s) begin
        resp_instr_d = 32'd0;
        resp_err_d   = 1'b1;
      end else begin
        resp_instr_d = lookup_word_s;
        resp_err_d   = 1'b0;
      end
    end else begin
      capture_s = 1'b0;
    end
  end

  // FSM and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      pc_q         <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= 32'd0;
      resp_instr_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pc_q         <= pc_d;
      resp_valid_q <= resp_valid_d;
      resp_pc_q    <= resp_pc_d;
      resp_instr_q <= resp_instr_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Program image array: loader writes only, never cleared, so contents
  // survive reset. A same-edge read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  localparam int          LAT  = 2;
  localparam logic [31:0] BASE = 32'h0000_3000;

  logic        clk;
  logic        reset;
  logic        prog_we;
  logic [11:0] prog_addr;
  logic [31:0] prog_data;

  imem_if bus();

  imem_responder #(
    .ADDR_WIDTH(12),
    .LATENCY   (LAT),
    .BASE_ADDR (BASE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data)
  );

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [31:0] m_mem [0:4095];
  bit          m_known = 1'b0;
  bit          m_busy  = 1'b0;
  int          m_due   = 0;
  int          m_edge  = 0;
  logic [31:0] m_pc    = 32'd0;
  logic        m_rv    = 1'b0;
  logic [31:0] m_rpc   = 32'd0;
  logic [31:0] m_rinstr = 32'd0;
  logic        m_rerr  = 1'b0;

  function automatic logic exp_err(input logic [31:0] pc);
    logic [31:0] off;
    off = pc - BASE;
    return (pc % 4 != 0) || (off / 4 >= 4096);
  endfunction

  task automatic deliver();
    logic [31:0] off;
    off      = m_pc - BASE;
    m_busy   = 1'b0;
    m_rv     = 1'b1;
    m_rpc    = m_pc;
    m_rerr   = exp_err(m_pc);
    m_rinstr = m_rerr ? 32'd0 : m_mem[off / 4];
  endtask

  always @(posedge clk) begin
    m_edge++;
    if (!reset) begin
      m_known  = 1'b1;
      m_busy   = 1'b0;
      m_rv     = 1'b0;
      m_rpc    = 32'd0;
      m_rinstr = 32'd0;
      m_rerr   = 1'b0;
    end else if (bus.flush) begin
      m_busy = 1'b0;
      m_rv   = 1'b0;
    end else if (m_rv) begin
      if (bus.resp_ready) m_rv = 1'b0;
    end else if (m_busy) begin
      if (m_edge == m_due) deliver();
    end else if (bus.req_valid) begin
      m_busy = 1'b1;
      m_pc   = bus.req_pc;
      m_due  = m_edge + LAT - 1;
      if (LAT == 1) deliver();
    end
    // write after the read so a same-edge hit returns the old word
    if (prog_we) m_mem[prog_addr] = prog_data;
  end

  // compare process: outputs are fully defined (including hold values)
  always @(negedge clk) begin
    if (m_known) begin
      chk("resp_valid", {31'd0, bus.resp_valid}, {31'd0, m_rv});
      chk("req_ready",  {31'd0, bus.req_ready},
          {31'd0, reset && !m_busy && !m_rv && !bus.flush});
      chk("resp_pc",    bus.resp_pc,    m_rpc);
      chk("resp_instr", bus.resp_instr, m_rinstr);
      chk("resp_err",   {31'd0, bus.resp_err}, {31'd0, m_rerr});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic load(input logic [11:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    cyc();
    prog_we = 1'b0;
  endtask

  task automatic send(input logic [31:0] pc);
    bus.req_valid = 1'b1; bus.req_pc = pc;
    cyc();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int n);
    n = 1;
    while (bus.resp_valid !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
  endtask

  task automatic consume();
    bus.resp_ready = 1'b1;
    cyc();
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b0; prog_we = 1'b0; prog_addr = 12'd0; prog_data = 32'd0;
    bus.req_valid = 1'b0; bus.req_pc = 32'd0; bus.flush = 1'b0; bus.resp_ready = 1'b0;
    repeat (3) cyc();
    chk("rst_ready",  {31'd0, bus.req_ready},  32'd0);
    chk("rst_valid",  {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_instr",  bus.resp_instr, 32'd0);
    reset = 1'b1;
    cyc();
    chk("ready_after_rst", {31'd0, bus.req_ready}, 32'd1);

    load(12'd0, 32'h3C010001);
    load(12'd1, 32'h34210002);

    // basic fetch and latency
    send(32'h0000_3000);
    wait_resp(n);
    chk("latency", n, 32'd2);
    chk("instr0", bus.resp_instr, 32'h3C010001);
    chk("err0", {31'd0, bus.resp_err}, 32'd0);
    consume();
    chk("ready_after_hs", {31'd0, bus.req_ready}, 32'd1);

    // backpressure: response must hold
    send(32'h0000_3004);
    wait_resp(n);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("hold_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("hold_pc",    bus.resp_pc,    32'h0000_3004);
      chk("hold_instr", bus.resp_instr, 32'h34210002);
      chk("hold_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    consume();

    // error cases
    send(32'h0000_3002); wait_resp(n);
    chk("mis_err", {31'd0, bus.resp_err}, 32'd1);
    chk("mis_instr", bus.resp_instr, 32'd0);
    consume();
    send(32'h0000_2FFC); wait_resp(n);
    chk("wrap_err", {31'd0, bus.resp_err}, 32'd1);
    consume();
    send(32'h0000_7000); wait_resp(n);
    chk("range_err", {31'd0, bus.resp_err}, 32'd1);
    chk("range_pc", bus.resp_pc, 32'h0000_7000);
    consume();

    // flush one cycle after acceptance
    send(32'h0000_3004);
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    #1;
    chk("ready_post_flush", {31'd0, bus.req_ready}, 32'd1);
    repeat (4) begin
      cyc();
      chk("flushed_no_resp", {31'd0, bus.resp_valid}, 32'd0);
    end
    // flush together with req_valid: not accepted
    bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_pc = 32'h0000_3000;
    #1;
    chk("ready_in_flush", {31'd0, bus.req_ready}, 32'd0);
    cyc();
    bus.flush = 1'b0; bus.req_valid = 1'b0;
    repeat (3) begin
      cyc();
      chk("flush_req_dropped", {31'd0, bus.resp_valid}, 32'd0);
    end
    send(32'h0000_3000); wait_resp(n);
    chk("post_flush_instr", bus.resp_instr, 32'h3C010001);
    consume();

    // reset while waiting
    send(32'h0000_3004);
    reset = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    repeat (3) begin
      cyc();
      chk("rst_drop", {31'd0, bus.resp_valid}, 32'd0);
    end
    send(32'h0000_3000); wait_resp(n);
    chk("mem_kept", bus.resp_instr, 32'h3C010001);
    consume();

    // loader write on the capture edge returns old data
    send(32'h0000_3004);
    prog_we = 1'b1; prog_addr = 12'd1; prog_data = 32'hDEADBEEF;
    cyc();
    prog_we = 1'b0;
    chk("same_edge_valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("same_edge_old", bus.resp_instr, 32'h34210002);
    consume();
    send(32'h0000_3004); wait_resp(n);
    chk("new_data", bus.resp_instr, 32'hDEADBEEF);
    consume();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder at the far end of the fetch interface.
- Accepts one PC request at a time from the fetch stage and returns the 32-bit instruction word after a fixed, parameterised latency.
- Uses a valid/ready handshake on both request and response channels.
- Supports flush cancellation when the pipeline redirects on a branch or jump. Includes a bench/loader write port to preload the program image.

Parameters:
- ADDR_WIDTH, 12, word-address bits of the internal array (depth 2^ADDR_WIDTH words).
- LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15.
- BASE_ADDR, 32'h00003000, byte address mapped to word 0.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- req_valid  input  1  fetch presents a PC
- req_ready  output  1  responder can accept a request this cycle
- req_pc  input  32  byte address of the instruction requested
- flush  input  1  cancel any outstanding or pending response
- resp_valid  output  1  resp_pc/resp_instr/resp_err valid
- resp_ready  input  1  fetch consumes the response
- resp_pc  output  32  PC belonging to the response
- resp_instr  output  32  instruction word (0 on error)
- resp_err  output  1  misaligned or out-of-range PC
- prog_we  input  1  loader write enable
- prog_addr  input  ADDR_WIDTH  loader word address
- prog_data  input  32  loader write data

Behaviour:
- Reset, sampled at a clk edge while reset==0:
  - State goes to IDLE; req_ready=0 while reset is held, 1 in the first cycle after release.
  - resp_valid=0, resp_pc=0, resp_instr=0, resp_err=0; latency counter=0.
  - Array contents are NOT cleared.
  - Reset mid-operation drops the outstanding request silently.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = ~flush.
  - req_valid&&req_ready at an edge: latch req_pc and load counter = LATENCY-1.
  - Go to RESP if LATENCY==1, else to WAIT.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - When counter==1 at the edge, go to RESP.
  - Total latency is exactly LATENCY cycles from the accepting edge to the first cycle with resp_valid=1.
- Entering RESP:
  - resp_pc = latched PC.
  - err = (pc[1:0]!=0) || ((pc-BASE_ADDR)>>2 >= 2^ADDR_WIDTH), using unsigned 32-bit subtraction so that a PC below BASE_ADDR wraps and flags as an error.
  - On err: resp_instr=0, resp_err=1.
  - Otherwise resp_instr = array[(pc-BASE_ADDR)>>2] as held before that edge, and resp_err=0.
- RESP:
  - resp_valid=1; outputs stay stable until resp_valid&&resp_ready at an edge, then go to IDLE.
  - req_ready=0, so there is no back-to-back acceptance in the same cycle. Maximum throughput is one request per LATENCY+1 cycles.
- Flush:
  - Flush high at an edge forces IDLE from any state and clears resp_valid.
  - It takes priority over req_valid and resp_ready in the same cycle; a response handshaking in the same cycle as flush is treated as discarded.
  - req_ready is 0 during a flush cycle.
- Loader:
  - prog_we writes array[prog_addr]=prog_data at the edge, independent of state.
  - If the write hits the same word in the same edge that the read is captured (entering RESP), the read returns the old data.
- resp_* outputs hold their last values when resp_valid=0. Only resp_valid is meaningful to consumers.

Test Plan:
- Load array[0]=32'h3C010001, array[1]=32'h34210002. Request PC 32'h00003000 with LATENCY=2 -> resp_valid rises exactly 2 cycles after acceptance, resp_instr=32'h3C010001, resp_err=0. With resp_ready=1 -> IDLE; req_ready=1 the next cycle.
- Hold resp_ready=0 for 5 cycles after response to PC 32'h00003004 -> resp_valid, resp_pc=32'h00003004 and resp_instr=32'h34210002 stay stable; req_ready=0 throughout.
- Request PC 32'h00003002 -> resp_err=1, resp_instr=0. Request PC 32'h00002FFC -> resp_err=1 (wrap below base). Request PC 32'h00007000 -> resp_err=1 (ADDR_WIDTH=12 limit).
- Flush one cycle after acceptance -> no resp_valid ever for that request; req_ready=1 the cycle after flush deasserts. Then request PC 32'h00003000 -> correct response. Also assert flush together with req_valid -> request not accepted.
- Assert reset=0 while in WAIT -> resp_valid stays 0; after release, array[0] still reads 32'h3C010001.
- Set prog_we to array[1]=32'hDEADBEEF on the edge entering RESP for PC 32'h00003004 -> response returns 32'h34210002; a repeated request returns 32'hDEADBEEF.
